// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the rPLL reconfiguration controller.
// Holds the sequencer state encoding and the channel-select width helper.
package pll_reconfig_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT_RST = 2'd1,
    WAIT_LOCK  = 2'd2,
    FINISH     = 2'd3
  } state_t;

  // A one-channel build still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL lock vector into the clkin domain.
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; only the second flop's output is consumed.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer that rewrites an rPLL channel's FBDSEL/IDSEL codes, pulses its
// reset and waits for lock, retrying on timeout.
// Optional lock-loss monitor is built when PLL_RECONFIG_LOSS_MON_EN is defined.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int              NUM_PLL      = 2,
  parameter int              DIV_W        = 6,
  parameter int              RST_CYCLES   = 16,
  parameter int              LOCK_TIMEOUT = 4096,
  parameter int              MAX_RETRY    = 2,
  parameter logic [DIV_W-1:0] FDIV_INIT   = '0,
  parameter logic [DIV_W-1:0] IDIV_INIT   = '0,
  localparam int             SEL_W        = sel_width(NUM_PLL)
) (
  input  logic                     clkin,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic [DIV_W-1:0]         req_fdiv,
  input  logic [DIV_W-1:0]         req_idiv,
  output logic [NUM_PLL*DIV_W-1:0] pll_fdiv,
  output logic [NUM_PLL*DIV_W-1:0] pll_idiv,
  output logic [NUM_PLL-1:0]       pll_reset,
  input  logic [NUM_PLL-1:0]       pll_lock,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NUM_PLL-1:0]       lock_lost
);

  localparam int RCNT_W = $clog2(RST_CYCLES) + 1;
  localparam int TCNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int RTRY_W = $clog2(MAX_RETRY + 1) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [SEL_W-1:0]    sel_q;
  logic [RCNT_W-1:0]   rst_cnt;
  logic [TCNT_W-1:0]   lock_timer;
  logic [RTRY_W-1:0]   retry_cnt;
  logic                fail_q;
  logic                bad_sel_q;
  logic [NUM_PLL-1:0]  lock_s;
  logic                accept;
  logic                sel_ok;
  logic                sel_lock;
  logic                rst_last;
  logic                timeout_hit;
  logic                retry_left;

  pll_lock_sync #(
    .WIDTH (NUM_PLL)
  ) u_lock_sync (
    .clkin    (clkin),
    .reset    (reset),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  assign accept      = req_valid && (state == IDLE);
  assign sel_ok      = (32'(req_sel) < NUM_PLL);
  assign rst_last    = (rst_cnt == RCNT_W'(RST_CYCLES - 1));
  assign timeout_hit = (lock_timer == TCNT_W'(LOCK_TIMEOUT - 1));
  assign retry_left  = (retry_cnt < RTRY_W'(MAX_RETRY));

  // Pick the synchronised lock of the channel currently being sequenced.
  always_comb begin
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_PLL; i++) begin
      if (sel_q == SEL_W'(i)) sel_lock = lock_s[i];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a lock seen in the timeout cycle counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept && sel_ok) state_nxt = ASSERT_RST;
      ASSERT_RST: if (rst_last) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (sel_lock)         state_nxt = FINISH;
        else if (timeout_hit) state_nxt = retry_left ? ASSERT_RST : FINISH;
      end
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake, status pulses and the per-channel reset drive.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == FINISH) && !fail_q;
    err       = ((state == FINISH) && fail_q) || bad_sel_q;
    pll_reset = '0;
    for (int i = 0; i < NUM_PLL; i++) begin
      pll_reset[i] = (state == ASSERT_RST) && (sel_q == SEL_W'(i));
    end
  end

  // Reset-hold and lock-wait timers run only in their own state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rst_cnt    <= '0;
      lock_timer <= '0;
    end else begin
      rst_cnt    <= (state == ASSERT_RST && !rst_last) ? rst_cnt + 1'b1 : '0;
      lock_timer <= (state == WAIT_LOCK && !timeout_hit) ? lock_timer + 1'b1 : '0;
    end
  end

  // Request capture, retry bookkeeping and the outcome flags.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      retry_cnt <= '0;
      fail_q    <= 1'b0;
      bad_sel_q <= 1'b0;
    end else begin
      bad_sel_q <= accept && !sel_ok;
      if (accept) begin
        sel_q     <= req_sel;
        retry_cnt <= '0;
        fail_q    <= 1'b0;
      end else if (state == WAIT_LOCK && !sel_lock && timeout_hit) begin
        if (retry_left) retry_cnt <= retry_cnt + 1'b1;
        else            fail_q    <= 1'b1;
      end
    end
  end

  // Divider codes change only for the channel named by an accepted request.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_fdiv <= {NUM_PLL{FDIV_INIT}};
      pll_idiv <= {NUM_PLL{IDIV_INIT}};
    end else if (accept && sel_ok) begin
      for (int i = 0; i < NUM_PLL; i++) begin
        if (req_sel == SEL_W'(i)) begin
          pll_fdiv[i*DIV_W +: DIV_W] <= req_fdiv;
          pll_idiv[i*DIV_W +: DIV_W] <= req_idiv;
        end
      end
    end
  end

`ifdef PLL_RECONFIG_LOSS_MON_EN
  logic [NUM_PLL-1:0] lock_prev;
  logic [NUM_PLL-1:0] lost_q;

  // Flag lock falling on any channel not mid-sequence; a new request clears it.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_prev <= '0;
      lost_q    <= '0;
    end else begin
      lock_prev <= lock_s;
      for (int i = 0; i < NUM_PLL; i++) begin
        if (accept && req_sel == SEL_W'(i))
          lost_q[i] <= 1'b0;
        else if (lock_prev[i] && !lock_s[i] && !(state != IDLE && sel_q == SEL_W'(i)))
          lost_q[i] <= 1'b1;
      end
    end
  end

  assign lock_lost = lost_q;
`else
  assign lock_lost = '0;
`endif

endmodule
